// File: rtl/key_event_gen.sv
// key_event_gen: turns a debounced 4-bit key vector into press, release
// and auto-repeat pulses plus a key code. Chords of two or more keys are
// locked out until every key has been let go.
module key_event_gen #(
  parameter int LONG_CYC = 25_000_000,  // hold time before the first repeat
  parameter int REP_CYC  = 5_000_000,   // spacing of later repeats
  parameter int CNT_W    = 25           // must cover max(LONG_CYC, REP_CYC)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] key_deb,
  output logic [1:0] key_code,
  output logic       key_press,
  output logic       key_release,
  output logic       key_repeat,
  output logic       key_held,
  output logic       key_err
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       latched;

  logic             is_none;
  logic             is_onehot;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt_last;

  // Decode the input vector: empty, single key (with its index), or chord.
  always_comb begin
    is_none   = (key_deb == 4'd0);
    is_onehot = !is_none && ((key_deb & (key_deb - 4'd1)) == 4'd0);
    idx       = 2'd0;
    case (key_deb)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    // The first repeat waits the long interval, later ones the short one.
    cnt_last  = (state == HOLD) ? LONG_LAST : REP_LAST;
  end

  // Main FSM; every output is registered and pulses default low each cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      latched     <= 4'd0;
      key_code    <= 2'd0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      key_held    <= 1'b0;
      key_err     <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      case (state)
        IDLE: begin
          if (is_onehot) begin
            state     <= HOLD;
            key_code  <= idx;
            latched   <= key_deb;
            key_press <= 1'b1;
            key_held  <= 1'b1;
            cnt       <= '0;
          end else if (!is_none) begin
            state   <= LOCK;
            key_err <= 1'b1;
          end
        end
        HOLD, REPEAT: begin
          if (key_deb == latched) begin
            // Compare-then-clear keeps the period exact and the counter
            // from ever wrapping.
            if (cnt == cnt_last) begin
              state      <= REPEAT;
              key_repeat <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (is_none) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_held    <= 1'b0;
            cnt         <= '0;
          end else begin
            // Key swapped or a second key added: release, then lock out.
            state       <= LOCK;
            key_release <= 1'b1;
            key_held    <= 1'b0;
            key_err     <= 1'b1;
            cnt         <= '0;
          end
        end
        LOCK: begin
          // Only a fully released keypad re-arms the detector.
          if (is_none) begin
            state   <= IDLE;
            key_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
